// File: rtl/scp_trace_pkg.sv
// -----------------------------------------------------------------------------
// scp_trace_pkg
// Shared constants and types for the single-cycle processor result tracer.
// A trace entry is laid out as {timestamp, flags[3:0], result[31:0]}, with the
// result in the least-significant bits. The offsets below describe that layout
// for any timestamp width.
// Optional build macro used by the tracer: SCP_TRACE_CHANGE_FILTER_EN.
// -----------------------------------------------------------------------------
package scp_trace_pkg;

  localparam int RESULT_W     = 32;
  localparam int FLAG_W       = 4;
  localparam int TS_W_DEFAULT = 16;

  // Field offsets inside a packed trace entry.
  localparam int RESULT_LSB = 0;
  localparam int FLAGS_LSB  = RESULT_LSB + RESULT_W;
  localparam int TS_LSB     = FLAGS_LSB + FLAG_W;

  // Entry width excluding the timestamp. It also serves as the width of the
  // change-filter compare value.
  localparam int SAMPLE_W = RESULT_W + FLAG_W;

  typedef struct packed {
    logic [TS_W_DEFAULT-1:0] ts;
    logic [FLAG_W-1:0]       flags;
    logic [RESULT_W-1:0]     result;
  } trace_entry_t;

endpackage

// File: rtl/trace_sync_fifo.sv
// -----------------------------------------------------------------------------
// trace_sync_fifo
// Generic show-ahead synchronous FIFO. The head entry is presented
// combinationally from registered storage. Output data reads as zero when the
// FIFO is empty.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   push, wr_data     write request and data; ignored when full unless a pop
//                     happens in the same cycle
//   push_ok           the write request was accepted this cycle
//   pop               advance the head; ignored when empty (no fall-through)
//   rd_data           head entry (zero when empty)
//   empty, full       occupancy flags derived from level
//   level             current occupancy, 0..DEPTH
// DEPTH must be a power of two so that the pointers wrap naturally.
// -----------------------------------------------------------------------------
module trace_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 52,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign level   = level_q;
  assign push_ok = do_push;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still
  // accepted when it is paired with a pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // The storage array needs no reset. Stale contents are never visible because
  // rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/scp_result_tracer.sv
// -----------------------------------------------------------------------------
// scp_result_tracer
// Observation stage for the single-cycle processor. It timestamps samples of
// the result bus and the NZCV flags, buffers them in a show-ahead FIFO, and
// drains them over a valid/ready handshake. The tracer never back-pressures
// the processor: a sample that arrives while the FIFO is full is dropped and
// counted in a saturating counter.
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   cap_en                  sample Result_Out/FlagReg this cycle
//   Result_Out, FlagReg     processor result bus and flag register
//   out_valid/out_ready     consumer handshake
//   out_data                head entry {timestamp, flags, result}, zero when idle
//   level                   FIFO occupancy
//   overflow, ovf_count     sticky drop flag and saturating drop count
//   ovf_clear               clears overflow/ovf_count; a drop in the same
//                           cycle takes priority
// Build option: define SCP_TRACE_CHANGE_FILTER_EN to push a sample only when
// {flags, result} differs from the last accepted sample.
// -----------------------------------------------------------------------------
module scp_result_tracer
  import scp_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = TS_W_DEFAULT,
  parameter int OVF_W = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       cap_en,
  input  logic [RESULT_W-1:0]        Result_Out,
  input  logic [FLAG_W-1:0]          FlagReg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W+SAMPLE_W-1:0]   out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [OVF_W-1:0]           ovf_count,
  input  logic                       ovf_clear
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TS_W + SAMPLE_W;

  logic [TS_W-1:0]     ts_q, ts_d;
  logic                overflow_q, overflow_d;
  logic [OVF_W-1:0]    ovf_count_q, ovf_count_d;
  logic [SAMPLE_W-1:0] sample;
  logic [ENT_W-1:0]    wr_entry;
  logic                push_req, push_ok, pop, drop, fifo_empty, fifo_full;

  assign sample   = {FlagReg, Result_Out};
  assign wr_entry = {ts_q, sample};
  assign pop      = out_valid && out_ready;
  assign drop     = push_req && !push_ok;

`ifdef SCP_TRACE_CHANGE_FILTER_EN
  logic [SAMPLE_W-1:0] last_q, last_d;
  logic                last_vld_q, last_vld_d;

  // Suppress repeats of the last accepted sample. Before the first accepted
  // push there is nothing to compare against, so that push always goes through.
  always_comb begin
    push_req   = cap_en && (!last_vld_q || (sample != last_q));
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (push_ok) begin
      last_d     = sample;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign push_req = cap_en;
`endif

  trace_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .push    (push_req),
    .wr_data (wr_entry),
    .push_ok (push_ok),
    .pop     (pop),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  assign out_valid = !fifo_empty;

  // The clear is applied first and the drop second. A drop in the same cycle
  // as a clear therefore leaves overflow=1 and a count of exactly one.
  always_comb begin
    ts_d        = ts_q + 1'b1;
    overflow_d  = overflow_q;
    ovf_count_d = ovf_count_q;
    if (ovf_clear) begin
      overflow_d  = 1'b0;
      ovf_count_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_count_d != '1) ovf_count_d = ovf_count_d + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ts_q        <= '0;
      overflow_q  <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      ts_q        <= ts_d;
      overflow_q  <= overflow_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign overflow  = overflow_q;
  assign ovf_count = ovf_count_q;

  // fifo_full is not used at this level: drops are detected from a rejected
  // push request, which already accounts for a simultaneous pop.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
